cnu_min_acc: RTL



---
 rtl/cnu_min_acc_pkg.sv | 16 +
 rtl/cnu_min_acc_if.sv | 34 +++
 rtl/cnu_min_acc_min2_update.sv | 37 +++
 rtl/cnu_min_acc.sv | 128 ++++++++++++
 4 files changed

// File: rtl/cnu_min_acc_pkg.sv
// rtl/cnu_min_acc_pkg.sv - shared CNU constants, defaults and state encoding
package cnu_min_acc_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 8;

  // All-ones magnitude doubles as the "no entry" sentinel for min1/min2
  localparam logic [DATA_W-1:0] MAG_MAX = {DATA_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/cnu_min_acc_if.sv
// rtl/cnu_min_acc_if.sv - message-in / sorted-pair-out handshake bundle
interface cnu_min_acc_if
  import cnu_min_acc_pkg::*;
#(
  parameter int unsigned data_w = DATA_W,
  parameter int unsigned idx_w  = IDX_W,
  parameter int unsigned cnt_w  = 6
);

  logic                  in_valid;
  logic                  in_ready;
  logic [data_w-1:0]     in_mag;
  logic                  in_sign;
  logic [idx_w-1:0]      in_idx;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*data_w-1:0]   out;
  logic [2*idx_w-1:0]    idx_out;
  logic                  sign_out;
  logic [cnt_w-1:0]      cnt_out;
  logic                  err;

  modport master (
    output in_valid, in_mag, in_sign, in_idx, in_last, out_ready,
    input  in_ready, out_valid, out, idx_out, sign_out, cnt_out, err
  );

  modport slave (
    input  in_valid, in_mag, in_sign, in_idx, in_last, out_ready,
    output in_ready, out_valid, out, idx_out, sign_out, cnt_out, err
  );

endinterface

// File: rtl/cnu_min_acc_min2_update.sv
// rtl/cnu_min_acc_min2_update.sv - insert (mag, idx) into a sorted two-minimum pair
module min2_update
  import cnu_min_acc_pkg::*;
#(
  parameter int unsigned data_w = DATA_W,
  parameter int unsigned idx_w  = IDX_W
) (
  input  logic [data_w-1:0] min1,
  input  logic [idx_w-1:0]  idx1,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  idx2,
  input  logic [data_w-1:0] mag,
  input  logic [idx_w-1:0]  idx,
  output logic [data_w-1:0] n_min1,
  output logic [idx_w-1:0]  n_idx1,
  output logic [data_w-1:0] n_min2,
  output logic [idx_w-1:0]  n_idx2
);

  // Strict compare: an equal magnitude never displaces the earlier edge
  always_comb begin
    n_min1 = min1;
    n_idx1 = idx1;
    n_min2 = min2;
    n_idx2 = idx2;
    if (mag < min1) begin
      n_min2 = min1;
      n_idx2 = idx1;
      n_min1 = mag;
      n_idx1 = idx;
    end else if (mag < min2) begin
      n_min2 = mag;
      n_idx2 = idx;
    end
  end

endmodule

// File: rtl/cnu_min_acc.sv
// rtl/cnu_min_acc.sv - serial min-sum accumulator producing one sorted pair per row
module cnu_min_acc
  import cnu_min_acc_pkg::*;
#(
  parameter int unsigned data_w  = DATA_W,
  parameter int unsigned idx_w   = IDX_W,
  parameter int unsigned max_deg = 32,
  parameter int unsigned cnt_w   = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  cnu_min_acc_if.slave bus
);

  localparam logic [cnt_w-1:0] MAX_CNT = cnt_w'(max_deg);

  state_t            state;
  logic [data_w-1:0] min1, min2;
  logic [idx_w-1:0]  idx1, idx2;
  logic              sign_acc;
  logic [cnt_w-1:0]  cnt;
  logic              out_valid_r, in_ready_r, err_r;

  logic [data_w-1:0] b_min1, b_min2, n_min1, n_min2;
  logic [idx_w-1:0]  b_idx1, b_idx2, n_idx1, n_idx2;
  logic              b_sign;
  logic [cnt_w-1:0]  b_cnt, n_cnt;
  logic              accept, at_max;

  // A new row starts from the cleared accumulator regardless of register contents
  always_comb begin
    b_min1 = min1;
    b_idx1 = idx1;
    b_min2 = min2;
    b_idx2 = idx2;
    b_sign = sign_acc;
    b_cnt  = cnt;
    if (state == IDLE) begin
      b_min1 = '1;
      b_idx1 = '0;
      b_min2 = '1;
      b_idx2 = '0;
      b_sign = 1'b0;
      b_cnt  = '0;
    end
  end

  assign accept = bus.in_valid && in_ready_r;
  assign n_cnt  = b_cnt + 1'b1;
  assign at_max = (n_cnt == MAX_CNT);

  min2_update #(.data_w(data_w), .idx_w(idx_w)) u_min2_update (
    .min1   (b_min1),
    .idx1   (b_idx1),
    .min2   (b_min2),
    .idx2   (b_idx2),
    .mag    (bus.in_mag),
    .idx    (bus.in_idx),
    .n_min1 (n_min1),
    .n_idx1 (n_idx1),
    .n_min2 (n_min2),
    .n_idx2 (n_idx2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      err_r       <= 1'b0;
      min1        <= '1;
      min2        <= '1;
      idx1        <= '0;
      idx2        <= '0;
      sign_acc    <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            min1     <= n_min1;
            idx1     <= n_idx1;
            min2     <= n_min2;
            idx2     <= n_idx2;
            sign_acc <= b_sign ^ bus.in_sign;
            cnt      <= n_cnt;
            if (bus.in_last || at_max) begin
              state       <= HOLD;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
              err_r       <= !bus.in_last;
            end else begin
              state <= ACC;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            err_r       <= 1'b0;
            min1        <= '1;
            min2        <= '1;
            idx1        <= '0;
            idx2        <= '0;
            sign_acc    <= 1'b0;
            cnt         <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = {min2, min1};
  assign bus.idx_out   = {idx2, idx1};
  assign bus.sign_out  = sign_acc;
  assign bus.cnt_out   = cnt;
  assign bus.err       = err_r;

endmodule
